unpacked_stream_arbiter: RTL and testbench
==========================================

# unpacked_stream_arbiter

Burst-granular arbiter that shares one unpacked-vector stream channel among `NUM_SRC` producers. Each source presents `IN_NUM` lanes of `DATA_WIDTH` bits under valid/ready. The arbiter grants one source for a fixed burst of `BEATS` accepted beats, then forwards them through a registered output stage. It sits ahead of the shared unpacked skid buffer / MX operator input, so tiles from different producers never interleave.

## Interface
Parameters:
- `DATA_WIDTH`, 8, bits per lane
- `IN_NUM`, 16, lanes per beat
- `NUM_SRC`, 4, number of requesting sources (≥2)
- `BEATS`, 4, accepted beats per granted burst (≥1)
- `SRC_W`, `$clog2(NUM_SRC)`, width of the source-ID field (derived, not overridden)
- `CNT_W`, `$clog2(BEATS+1)`, width of the beat counter (derived)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `data_in` in `[NUM_SRC-1:0][IN_NUM-1:0]` × `DATA_WIDTH`: per-source unpacked beat
- `data_in_valid` in `NUM_SRC`: per-source valid
- `data_in_ready` out `NUM_SRC`: per-source ready (at most one bit high)
- `data_out` out `[IN_NUM-1:0]` × `DATA_WIDTH`: forwarded beat
- `data_out_valid` out 1: output valid
- `data_out_ready` in 1: downstream ready
- `data_out_src` out `SRC_W`: index of the source that produced `data_out`
- `data_out_last` out 1: high on the final beat of a burst

## Operation
- States: `IDLE`, `BURST`.
- `IDLE`:
  - All `data_in_ready` bits are 0.
  - If any `data_in_valid` bit is set, pick winner `g` per the arbitration policy, register it, clear the beat counter, and go to `BURST`.
  - If no valid bit is set, stay in `IDLE`.
- `BURST`:
  - `data_in_ready[g] = !data_out_valid || data_out_ready`. All other ready bits are 0.
  - An accept is `data_in_valid[g] && data_in_ready[g]`.
  - On an accept, load `data_out` with `data_in[g]`, load `data_out_src` with `g`, set `data_out_valid`, and increment the counter.
  - `data_out_last` is set when the counter reaches `BEATS-1` before the increment.
  - On that last accept, go to `IDLE` and update the round-robin pointer to `g+1` (mod `NUM_SRC`).
  - If the granted source deasserts valid mid-burst, the grant is held. There is no timeout and no preemption.
- Output register:
  - `data_out_valid` clears when `data_out_ready` is high and no accept occurs in that cycle.
  - `data_out`, `data_out_src` and `data_out_last` hold while `data_out_valid && !data_out_ready`.
- Valid/ready rules:
  - Downstream must see `data_out*` stable while valid and not ready.
  - Sources may change `data_in` only after an accept.
- Source-ID arithmetic:
  - `data_out_src` is unsigned.
  - Pointer wrap: `NUM_SRC-1` → 0.
  - The counter never exceeds `BEATS-1`.

## Timing
- Reset values (async assert, sync release):
  - State `IDLE`, grant 0, counter 0, pointer 0.
  - `data_out_valid` 0, `data_out` all 0, `data_out_src` 0, `data_out_last` 0.
  - `data_in_ready` all 0.
- Latency: a beat accepted at edge N appears on `data_out` after edge N.
- Arbitration cost: one `IDLE` cycle per burst.
- Steady-state throughput: `BEATS` beats per `BEATS+1` cycles when `data_out_ready` is held high.
- The last beat of a burst may drain from the output register during the `IDLE` cycle. The next burst's first accept can occur one cycle after `IDLE`.
- Simultaneous events:
  - An accept and a downstream pop in the same cycle replace the register contents; valid stays 1.
  - A requester asserting valid during another source's burst waits; its data is untouched.
- Reset mid-burst discards the registered beat and the grant. No partial-burst recovery.

## Configuration
- `UNPACKED_ARB_RR_EN` defined: round-robin. The search starts at the pointer and wraps, and the pointer advances past the winner after each burst completes.
- `UNPACKED_ARB_RR_EN` undefined: fixed priority. The lowest-index valid source wins, and the pointer logic is removed.
- Everything else is identical in both builds.

## Test plan
- Reset, then drive all valid bits to 0 → outputs hold reset values and all `data_in_ready` bits stay 0 for 10 cycles.
- `NUM_SRC=4`, `BEATS=4`, only source 2 valid, lane i = i, `data_out_ready=1`:
  - 4 beats appear with `data_out_src=2`.
  - `data_out_last` is high on the 4th beat only.
  - One bubble separates this burst from the next one.
- All sources continuously valid, `UNPACKED_ARB_RR_EN` defined → burst grant order 0,1,2,3,0; no interleaving within a burst.
- Same stimulus, macro undefined → every burst is granted to source 0.
- `data_out_ready` toggling 1,0,0,1 during a burst → `data_out`, `data_out_src` and `data_out_last` stay stable while stalled; no beat is lost or duplicated; `data_in_ready[g]` follows the stall.
- Assert `rst` low after 2 of 4 beats, then release → `data_out_valid` drops to 0 immediately, state is `IDLE`, and the next grant goes to source 0.

Source files
------------

// File: rtl/unpacked_stream_arbiter.sv
// Burst-granular arbiter: one of NUM_SRC unpacked-vector streams owns the output for BEATS beats.
// Build option UNPACKED_ARB_RR_EN selects round-robin; when undefined the lowest-index requester wins.
module unpacked_stream_arbiter #(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned IN_NUM     = 16,
   parameter  int unsigned NUM_SRC    = 4,
   parameter  int unsigned BEATS      = 4,
   localparam int unsigned SRC_W      = $clog2(NUM_SRC),
   localparam int unsigned CNT_W      = $clog2(BEATS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in [NUM_SRC-1:0][IN_NUM-1:0],
   input  logic [NUM_SRC-1:0]    data_in_valid,
   output logic [NUM_SRC-1:0]    data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out [IN_NUM-1:0],
   output logic                  data_out_valid,
   input  logic                  data_out_ready,
   output logic [SRC_W-1:0]      data_out_src,
   output logic                  data_out_last
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
   localparam logic [SRC_W-1:0] MAX_SRC  = SRC_W'(NUM_SRC - 1);

   state_t           state, state_nxt;
   logic [SRC_W-1:0] grant, grant_nxt;
   logic [SRC_W-1:0] win, idx, base;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             win_found;
   logic             slot_free;
   logic             accept;
   logic             last_beat;

`ifdef UNPACKED_ARB_RR_EN
   logic [SRC_W-1:0] ptr;

   assign base = ptr;

   // Pointer moves just past the source whose burst has completed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (accept && last_beat) begin
         ptr <= (grant == MAX_SRC) ? '0 : grant + SRC_W'(1);
      end
   end
`else
   assign base = '0;
`endif

   // First valid requester found scanning upward from base, wrapping at NUM_SRC.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      idx       = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = SRC_W'((32'(base) + i) % NUM_SRC);
         if (!win_found && data_in_valid[idx]) begin
            win       = idx;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      cnt_nxt       = cnt;
      data_in_ready = '0;
      accept        = 1'b0;
      slot_free     = !data_out_valid || data_out_ready;
      last_beat     = (cnt == LAST_CNT);
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt = BURST;
               grant_nxt = win;
               cnt_nxt   = '0;
            end
         end
         BURST: begin
            data_in_ready[grant] = slot_free;
            accept               = data_in_valid[grant] && slot_free;
            if (accept) begin
               if (last_beat) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         grant <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Output stage: refill on accept, otherwise drop valid once popped; payload holds while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_valid <= 1'b0;
         data_out_src   <= '0;
         data_out_last  <= 1'b0;
         data_out       <= '{default: '0};
      end else if (accept) begin
         data_out_valid <= 1'b1;
         data_out_src   <= grant;
         data_out_last  <= last_beat;
         data_out       <= data_in[grant];
      end else if (data_out_ready) begin
         data_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_unpacked_stream_arbiter.sv
// Bench for unpacked_stream_arbiter: per-source beat queues, a transaction-level burst model
// and a per-cycle output compare, plus literal expectations for order, latency and reset.
module tb_unpacked_stream_arbiter;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned IN_NUM     = 16;
   localparam int unsigned NUM_SRC    = 4;
   localparam int unsigned BEATS      = 4;

   typedef struct {
      int src;
      int serial;
      bit last;
   } exp_t;

   typedef struct {
      int cyc;
      int src;
      bit last;
      int lane5;
   } hs_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [DATA_WIDTH-1:0] data_in [NUM_SRC-1:0][IN_NUM-1:0];
   logic [NUM_SRC-1:0]    data_in_valid;
   logic [NUM_SRC-1:0]    data_in_ready;
   logic [DATA_WIDTH-1:0] data_out [IN_NUM-1:0];
   logic                  data_out_valid;
   logic                  data_out_ready;
   logic [1:0]            data_out_src;
   logic                  data_out_last;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   rem  [NUM_SRC];
   int   sent [NUM_SRC];
   int   model_ptr;
   int   rdy_phase;
   bit   chk_en     = 1'b0;
   bit   stall_mode = 1'b0;
   bit   rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int   exp_order [6];
   exp_t exp_q[$];
   hs_t  hs[$];
   exp_t cur;

   unpacked_stream_arbiter #(
      .DATA_WIDTH(DATA_WIDTH),
      .IN_NUM    (IN_NUM),
      .NUM_SRC   (NUM_SRC),
      .BEATS     (BEATS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .data_out_src  (data_out_src),
      .data_out_last (data_out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_WIDTH-1:0] beat_val(input int s, input int n, input int i);
      return 8'(s * 64 + (n % 4) * 16 + i);
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   // Each source shows its next queued beat while it has beats left.
   task automatic present();
      for (int s = 0; s < NUM_SRC; s++) begin
         data_in_valid[s] = (rem[s] > 0);
         for (int i = 0; i < IN_NUM; i++) data_in[s][i] = beat_val(s, sent[s], i);
      end
   endtask

   // One clock: sample accepts mid-cycle, then advance the source queues after the edge.
   task automatic step();
      logic [NUM_SRC-1:0] acc;
      @(negedge clk);
      acc = data_in_valid & data_in_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (acc[s]) begin
            rem[s]--;
            sent[s]++;
         end
      end
      if (stall_mode) begin
         data_out_ready = rdy_pat[rdy_phase % 4];
         rdy_phase++;
      end
      present();
   endtask

   // Queue whole bursts on the sources and predict the output beat sequence at burst level.
   task automatic plan(input int b0, input int b1, input int b2, input int b3);
      int cnt [NUM_SRC];
      int ser [NUM_SRC];
      int g;
      bit found;
      cnt = '{b0, b1, b2, b3};
      for (int s = 0; s < NUM_SRC; s++) begin
         ser[s] = sent[s] + rem[s];
         rem[s] += cnt[s] * BEATS;
      end
      for (int iter = 0; iter < 64; iter++) begin
         found = 1'b0;
         g     = 0;
`ifdef UNPACKED_ARB_RR_EN
         for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && cnt[(model_ptr + k) % NUM_SRC] > 0) begin
               g     = (model_ptr + k) % NUM_SRC;
               found = 1'b1;
            end
         end
`else
         for (int s = 0; s < NUM_SRC; s++) begin
            if (!found && cnt[s] > 0) begin
               g     = s;
               found = 1'b1;
            end
         end
`endif
         if (found) begin
            for (int b = 0; b < BEATS; b++) exp_q.push_back('{g, ser[g] + b, (b == BEATS - 1)});
            ser[g]   += BEATS;
            cnt[g]--;
            model_ptr = (g + 1) % NUM_SRC;
         end
      end
      present();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || data_out_valid) && n < 300) begin
         step();
         n++;
      end
      chk(name, exp_q.size(), 0);
      chk({name, "_valid"}, int'(data_out_valid), 0);
   endtask

   task automatic do_reset();
      chk_en         = 1'b0;
      rst            = 1'b0;
      stall_mode     = 1'b0;
      data_out_ready = 1'b1;
      for (int s = 0; s < NUM_SRC; s++) rem[s] = 0;
      present();
      exp_q.delete();
      hs.delete();
      model_ptr = 0;
      step();
      step();
      rst = 1'b1;
      step();
      chk_en = 1'b1;
   endtask

   // Per-cycle compare against the model's beat queue; a stalled beat must match the same head.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready_onehot", int'($countones(data_in_ready) <= 1), 1);
         if (data_out_valid && !data_out_ready) chk("ready_during_stall", int'(data_in_ready), 0);
         if (data_out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat_src", int'(data_out_src), -1);
            end else begin
               cur = exp_q[0];
               chk("out_src", int'(data_out_src), cur.src);
               chk("out_last", int'(data_out_last), int'(cur.last));
               for (int i = 0; i < IN_NUM; i++)
                  chk("out_lane", int'(data_out[i]), int'(beat_val(cur.src, cur.serial, i)));
               if (data_out_ready) begin
                  hs.push_back('{cyc, int'(data_out_src), data_out_last, int'(data_out[5])});
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
`ifdef UNPACKED_ARB_RR_EN
      exp_order = '{0, 1, 2, 3, 0, 0};
`else
      exp_order = '{0, 0, 0, 1, 2, 3};
`endif
      data_out_ready = 1'b1;
      rdy_phase      = 0;
      model_ptr      = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
         rem[s]  = 0;
         sent[s] = 0;
      end
      present();

      // Reset values while held in reset.
      #2 rst = 1'b0;
      #1;
      chk("rst_valid", int'(data_out_valid), 0);
      chk("rst_src", int'(data_out_src), 0);
      chk("rst_last", int'(data_out_last), 0);
      chk("rst_ready", int'(data_in_ready), 0);
      for (int i = 0; i < IN_NUM; i++) chk("rst_lane", int'(data_out[i]), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // No requests: everything holds reset values.
      for (int k = 0; k < 10; k++) begin
         step();
         chk("idle_valid", int'(data_out_valid), 0);
         chk("idle_ready", int'(data_in_ready), 0);
         chk("idle_src", int'(data_out_src), 0);
         chk("idle_last", int'(data_out_last), 0);
         chk("idle_lane3", int'(data_out[3]), 0);
      end

      // Single requester, two bursts, free-running downstream.
      do_reset();
      plan(0, 0, 2, 0);
      drain("single_drain");
      chk("single_beats", hs.size(), 8);
      if (hs.size() >= 8) begin
         for (int k = 0; k < 8; k++) begin
            chk("single_src", hs[k].src, 2);
            chk("single_last", int'(hs[k].last), int'(k % 4 == 3));
         end
         for (int k = 1; k < 8; k++) chk("single_gap", hs[k].cyc - hs[k-1].cyc, (k == 4) ? 2 : 1);
         chk("single_lane5_b0", hs[0].lane5, 133);
         chk("single_lane5_b3", hs[3].lane5, 181);
      end

      // All sources requesting: burst order follows the arbitration policy.
      do_reset();
      plan(3, 1, 1, 1);
      drain("arb_drain");
      chk("arb_beats", hs.size(), 24);
      if (hs.size() >= 24) begin
         for (int b = 0; b < 6; b++) chk("arb_order", hs[b*4].src, exp_order[b]);
      end

      // Downstream ready toggling 1,0,0,1 throughout two bursts.
      do_reset();
      stall_mode = 1'b1;
      rdy_phase  = 0;
      plan(0, 1, 1, 0);
      drain("stall_drain");
      stall_mode     = 1'b0;
      data_out_ready = 1'b1;
      chk("stall_beats", hs.size(), 8);
      if (hs.size() >= 8) begin
         chk("stall_first_src", hs[0].src, 1);
         chk("stall_second_src", hs[4].src, 2);
         chk("stall_last", int'(hs[7].last), 1);
      end

      // Reset in the middle of the second burst; next grant restarts from source 0.
      do_reset();
      plan(0, 1, 1, 0);
      n = 0;
      while (hs.size() < 6 && n < 100) begin
         step();
         n++;
      end
      chk("midrst_reached", hs.size(), 6);
      chk_en = 1'b0;
      rst    = 1'b0;
      #1;
      chk("midrst_valid", int'(data_out_valid), 0);
      chk("midrst_ready", int'(data_in_ready), 0);
      chk("midrst_src", int'(data_out_src), 0);
      chk("midrst_last", int'(data_out_last), 0);
      do_reset();
      chk("midrst_idle_ready", int'(data_in_ready), 0);
      plan(1, 0, 0, 1);
      drain("midrst_drain");
      chk("midrst_beats", hs.size(), 8);
      if (hs.size() >= 8) begin
         chk("midrst_first_src", hs[0].src, 0);
         chk("midrst_second_src", hs[4].src, 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
